mux_nt1_seq: RTL and testbench

Parametrised, registered N-to-1 operand selector for the RK datapath: generalises the combinational 4:1 word mux to `CH` channels of `N`-bit signed data. It has a valid/ready output handshake and two modes. Direct mode is a one-word-per-handshake registered select. Sequence mode snapshots all channels and streams them out in order, so the k1..k4 stage values can feed the single shared accumulator. It sits between the stage-result registers and the weighted-sum unit.

---
 rtl/mux_seq_pkg.sv | 12 +
 rtl/mux_nt1_sel.sv | 25 ++
 rtl/mux_nt1_seq.sv | 166 ++++++++++++++++
 tb/tb_mux_nt1_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared constants for the N:1 sequencing operand selector:
// FSM state encodings and the MODE input values.
package mux_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_SEQ  = 2'd2;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/mux_nt1_sel.sv
// Combinational CH:1 word selector over a flattened channel bus.
// An out-of-range select returns zero and raises o_err.
module mux_nt1_sel #(
   parameter int N     = 4,
   parameter int CH    = 4,
   parameter int SEL_W = $clog2(CH)
) (
   input  logic [CH*N-1:0]  i_data,
   input  logic [SEL_W-1:0] i_sel,
   output logic [N-1:0]     o_word,
   output logic             o_err
);

   always_comb begin
      o_word = '0;
      o_err  = 1'b1;
      for (int i = 0; i < CH; i++) begin
         if (i_sel == SEL_W'(i)) begin
            o_word = i_data[i*N +: N];
            o_err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_nt1_seq.sv
// Registered N:1 operand selector with a valid/ready output stage.
// Direct mode forwards one selected word per request; sequence mode streams a frozen snapshot.
module mux_nt1_seq
   import mux_seq_pkg::*;
#(
   parameter int N     = 4,
   parameter int CH    = 4,
   parameter int SEL_W = $clog2(CH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             MODE,
   input  logic [SEL_W-1:0] SEL,
   input  logic [CH*N-1:0]  D_IN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             START,
   output logic [N-1:0]     D_OUT,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [SEL_W-1:0] OUT_CH,
   output logic             OUT_LAST,
   output logic             SEL_ERR,
   output logic             BUSY,
   output logic             DONE,
   output logic [1:0]       DBG_STATE
);

   // Handshake: a word moves on any cycle where OUT_VALID && OUT_READY (likewise
   // IN_VALID && IN_READY for direct requests); D_OUT and its tags stay stable otherwise.

   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CH - 1);

   logic [1:0]       r_state;
   logic [CH*N-1:0]  r_shadow;
   logic [SEL_W-1:0] r_idx;
   logic [N-1:0]     r_dout;
   logic [SEL_W-1:0] r_out_ch;
   logic             r_out_valid;
   logic             r_out_last;
   logic             r_sel_err;
   logic             r_busy;
   logic             r_done;

   logic [1:0]       w_state_nxt;
   logic             w_dir_req;
   logic             w_load_direct;
   logic             w_load_seq;
   logic             w_seq_adv;
   logic             w_seq_end;
   logic [SEL_W-1:0] w_idx_nxt;
   logic [N-1:0]     w_dir_word;
   logic             w_dir_err;
   logic [N-1:0]     w_shd_word;
   logic             w_shd_err;

   assign w_dir_req = (MODE == MODE_DIRECT) && IN_VALID;
   assign w_idx_nxt = r_idx + SEL_W'(1);

   mux_nt1_sel #(.N(N), .CH(CH), .SEL_W(SEL_W)) u_sel_dir (
      .i_data (D_IN),
      .i_sel  (SEL),
      .o_word (w_dir_word),
      .o_err  (w_dir_err)
   );

   // Sequence words come from the snapshot so D_IN may change mid-stream.
   mux_nt1_sel #(.N(N), .CH(CH), .SEL_W(SEL_W)) u_sel_shd (
      .i_data (r_shadow),
      .i_sel  (w_idx_nxt),
      .o_word (w_shd_word),
      .o_err  (w_shd_err)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_load_direct = 1'b0;
      w_load_seq    = 1'b0;
      w_seq_adv     = 1'b0;
      w_seq_end     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_dir_req) begin
               w_load_direct = 1'b1;
               w_state_nxt   = ST_HOLD;
            end else if ((MODE == MODE_SEQ) && START) begin
               w_load_seq  = 1'b1;
               w_state_nxt = ST_SEQ;
            end
         end
         ST_HOLD: begin
            if (OUT_READY) begin
               if (w_dir_req) begin
                  w_load_direct = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_SEQ: begin
            if (OUT_READY) begin
               if (r_idx == IDX_LAST) begin
                  w_seq_end   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_seq_adv = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_idx       <= '0;
         r_dout      <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_sel_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != ST_IDLE);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= w_seq_end;
         if (w_load_direct) begin
            r_dout     <= w_dir_word;
            r_out_ch   <= SEL;
            r_out_last <= 1'b1;
            r_sel_err  <= w_dir_err;
         end else if (w_load_seq) begin
            r_shadow   <= D_IN;
            r_dout     <= D_IN[N-1:0];
            r_out_ch   <= '0;
            r_idx      <= '0;
            r_out_last <= 1'b0;
            r_sel_err  <= 1'b0;
         end else if (w_seq_adv) begin
            r_idx      <= w_idx_nxt;
            r_dout     <= w_shd_word;
            r_out_ch   <= w_idx_nxt;
            r_out_last <= (w_idx_nxt == IDX_LAST);
            r_sel_err  <= w_shd_err;
         end
      end
   end

   // Gated by RST_N so no request is acknowledged while reset is held.
   assign IN_READY = RST_N && (MODE == MODE_DIRECT) &&
                     ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && OUT_READY));

   assign D_OUT     = r_dout;
   assign OUT_VALID = r_out_valid;
   assign OUT_CH    = r_out_ch;
   assign OUT_LAST  = r_out_last;
   assign SEL_ERR   = r_sel_err;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mux_nt1_seq.sv
// Directed bench for mux_nt1_seq: a CH=4 instance for direct/sequence/reset cases
// and a CH=3 instance for the out-of-range select case.
module tb_mux_nt1_seq;

   localparam int N  = 16;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode;
   logic [SW-1:0] sel;
   logic [4*N-1:0] d_in;
   logic          in_valid;
   logic          start;
   logic          out_ready;

   logic          in_ready;
   logic [N-1:0]  d_out;
   logic          out_valid;
   logic [SW-1:0] out_ch;
   logic          out_last;
   logic          sel_err;
   logic          busy;
   logic          done;
   logic [1:0]    dbg_state;

   logic [3*N-1:0] d_in3;
   logic          in_valid3;
   logic          start3;
   logic          in_ready3;
   logic [N-1:0]  d_out3;
   logic          out_valid3;
   logic [SW-1:0] out_ch3;
   logic          out_last3;
   logic          sel_err3;
   logic          busy3;
   logic          done3;
   logic [1:0]    dbg_state3;

   // Scoreboard entry: {ch, last, err, data}
   logic [SW+2+N-1:0] exp_q[$];
   logic [SW+2+N-1:0] exp3_q[$];

   int n_vec    = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   assign d_in3 = d_in[3*N-1:0];

   always #5 clk = ~clk;

   mux_nt1_seq #(.N(N), .CH(4)) u_dut (
      .CLK(clk), .RST_N(rst_n), .MODE(mode), .SEL(sel), .D_IN(d_in),
      .IN_VALID(in_valid), .IN_READY(in_ready), .START(start),
      .D_OUT(d_out), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_CH(out_ch), .OUT_LAST(out_last), .SEL_ERR(sel_err),
      .BUSY(busy), .DONE(done), .DBG_STATE(dbg_state)
   );

   mux_nt1_seq #(.N(N), .CH(3)) u_dut3 (
      .CLK(clk), .RST_N(rst_n), .MODE(mode), .SEL(sel), .D_IN(d_in3),
      .IN_VALID(in_valid3), .IN_READY(in_ready3), .START(start3),
      .D_OUT(d_out3), .OUT_VALID(out_valid3), .OUT_READY(out_ready),
      .OUT_CH(out_ch3), .OUT_LAST(out_last3), .SEL_ERR(sel_err3),
      .BUSY(busy3), .DONE(done3), .DBG_STATE(dbg_state3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW+2+N-1:0] item(input int ch, input logic last,
                                              input logic err, input logic [N-1:0] data);
      return {SW'(ch), last, err, data};
   endfunction

   // Output monitor: every accepted word is popped and compared.
   always @(negedge clk) begin
      logic [SW+2+N-1:0] w;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL dut4_extra_word: observed %h expected none", d_out);
         end else begin
            w = exp_q.pop_front();
            chk("dut4_word", 32'({out_ch, out_last, sel_err, d_out}), 32'(w));
         end
      end
      if (rst_n && out_valid3 && out_ready) begin
         if (exp3_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL dut3_extra_word: observed %h expected none", d_out3);
         end else begin
            w = exp3_q.pop_front();
            chk("dut3_word", 32'({out_ch3, out_last3, sel_err3, d_out3}), 32'(w));
         end
      end
      if (rst_n && done) done_cnt++;
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; d_in = '0; in_valid = 1'b0;
      start = 1'b0; out_ready = 1'b0; in_valid3 = 1'b0; start3 = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_d_out", 32'(d_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Direct back-to-back
      d_in = {16'h8000, 16'h1234, 16'hFFFD, 16'h0004};
      mode = 1'b0; in_valid = 1'b1; sel = 2'd2; out_ready = 1'b1;
      #1;
      chk("b2b_in_ready0", 32'(in_ready), 32'd1);
      exp_q.push_back(item(2, 1'b1, 1'b0, 16'h1234));
      tick();
      sel = 2'd3;
      #1;
      chk("b2b_in_ready1", 32'(in_ready), 32'd1);
      chk("b2b_d_out0", 32'(d_out), 32'h1234);
      exp_q.push_back(item(3, 1'b1, 1'b0, 16'h8000));
      tick();
      in_valid = 1'b0;
      chk("b2b_d_out1", 32'(d_out), 32'h8000);
      chk("b2b_out_ch1", 32'(out_ch), 32'd3);
      tick();
      chk("b2b_idle_valid", 32'(out_valid), 32'd0);
      chk("b2b_idle_busy", 32'(busy), 32'd0);

      // Direct stall
      sel = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(item(1, 1'b1, 1'b0, 16'hFFFD));
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_d_out", 32'(d_out), 32'hFFFD);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("stall_idle", 32'(dbg_state), 32'd0);

      // Sequence with D_IN change and mid-stream START
      mode = 1'b1; start = 1'b1; in_valid = 1'b1;
      #1;
      chk("seq_in_ready_idle", 32'(in_ready), 32'd0);
      exp_q.push_back(item(0, 1'b0, 1'b0, 16'h0004));
      exp_q.push_back(item(1, 1'b0, 1'b0, 16'hFFFD));
      exp_q.push_back(item(2, 1'b0, 1'b0, 16'h1234));
      exp_q.push_back(item(3, 1'b1, 1'b0, 16'h8000));
      tick();
      d_in = {4{16'h7777}};
      for (int i = 0; i < 5; i++) begin
         out_ready = (i != 1);
         start = (i == 2);
         #1;
         chk("seq_valid", 32'(out_valid), 32'd1);
         chk("seq_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      start = 1'b0; in_valid = 1'b0;
      chk("seq_done_hi", 32'(done), 32'd1);
      chk("seq_busy_lo", 32'(busy), 32'd0);
      tick();
      chk("seq_done_lo", 32'(done), 32'd0);
      chk("seq_done_cnt", 32'(done_cnt), 32'd1);
      chk("seq_q_empty", 32'(exp_q.size()), 32'd0);
      d_in = {16'h8000, 16'h1234, 16'hFFFD, 16'h0004};

      // Out-of-range select on CH=3
      mode = 1'b0; sel = 2'd3; in_valid3 = 1'b1; out_ready = 1'b1;
      exp3_q.push_back(item(3, 1'b1, 1'b1, 16'h0000));
      tick();
      chk("oor_sel_err", 32'(sel_err3), 32'd1);
      chk("oor_d_out", 32'(d_out3), 32'd0);
      sel = 2'd0;
      exp3_q.push_back(item(0, 1'b1, 1'b0, 16'h0004));
      tick();
      in_valid3 = 1'b0;
      chk("oor_clear", 32'(sel_err3), 32'd0);
      chk("oor_word0", 32'(d_out3), 32'h0004);
      tick();
      chk("oor_q_empty", 32'(exp3_q.size()), 32'd0);

      // MODE change in HOLD
      sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(item(0, 1'b1, 1'b0, 16'h0004));
      tick();
      mode = 1'b1; out_ready = 1'b1;
      #1;
      chk("mchg_in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("mchg_idle", 32'(out_valid), 32'd0);
      start = 1'b1;
      exp_q.push_back(item(0, 1'b0, 1'b0, 16'h0004));
      exp_q.push_back(item(1, 1'b0, 1'b0, 16'hFFFD));
      exp_q.push_back(item(2, 1'b0, 1'b0, 16'h1234));
      exp_q.push_back(item(3, 1'b1, 1'b0, 16'h8000));
      tick();
      start = 1'b0;
      chk("mchg_seq_busy", 32'(busy), 32'd1);
      chk("mchg_seq_state", 32'(dbg_state), 32'd2);
      tick();
      tick();

      // Reset mid-sequence
      chk("rst_q_left", 32'(exp_q.size()), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("arst_d_out", 32'(d_out), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ch", 32'(out_ch), 32'd0);
      chk("arst_last", 32'(out_last), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      mode = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_state", 32'(dbg_state), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
